sha_nonce_scheduler: RTL

SHA_NONCE_SCHEDULER -- requirements
Module: sha_nonce_scheduler

---
 rtl/sha_sched_pkg.sv | 52 +++++
 rtl/sha_nonce_scheduler.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sha_sched_pkg.sv
// Shared definitions for the nonce scheduler: state encoding, SHA-256 initial
// value, padding constants and the builders for the pass-2 / pass-3 blocks.
package sha_sched_pkg;

  // State encoding. Kept as plain constants so older tools and netlists can
  // use the same values.
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_P1_ISSUE = 4'd1;
  localparam state_t ST_P1_WAIT  = 4'd2;
  localparam state_t ST_P2_ISSUE = 4'd3;
  localparam state_t ST_P2_WAIT  = 4'd4;
  localparam state_t ST_P3_ISSUE = 4'd5;
  localparam state_t ST_P3_WAIT  = 4'd6;
  localparam state_t ST_EMIT     = 4'd7;
  localparam state_t ST_DONE     = 4'd8;

  // Element [i] of each packed array is word i.
  typedef logic [15:0][31:0] block_t;
  typedef logic [7:0][31:0]  hash_t;

  localparam hash_t SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  localparam logic [31:0] LEN_640  = 32'h0000_0280;
  localparam logic [31:0] LEN_256  = 32'h0000_0100;

  // Second block of the 80-byte header: three tail words, nonce, padding.
  function automatic block_t p2_block(input logic [2:0][31:0] tail, input logic [31:0] nonce);
    block_t b;
    b        = '0;
    b[2:0]   = tail;
    b[3]     = nonce;
    b[4]     = PAD_WORD;
    b[15]    = LEN_640;
    return b;
  endfunction

  // Single block hashing the 256-bit first digest.
  function automatic block_t p3_block(input hash_t h);
    block_t b;
    b      = '0;
    b[7:0] = h;
    b[8]   = PAD_WORD;
    b[15]  = LEN_256;
    return b;
  endfunction

endpackage

// File: rtl/sha_nonce_scheduler.sv
// Sweeps nonces 0..NUM_NONCES-1 over a block header, driving a shared SHA-256
// core through a midstate pass (once per job) followed by two passes per nonce.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start, header     job request (sampled in IDLE) and 19 header words
//   busy, done        job in progress / one-cycle completion pulse
//   result_valid      one-cycle pulse per nonce with result_nonce, result_h0
//   sha_start         one-cycle start pulse to the core
//   sha_w             registered message block for the core
//   sha_hash_in       registered chaining value for the core
//   sha_hash_out      core digest, valid while sha_done is high
//   sha_done          core completion pulse
module sha_nonce_scheduler
  import sha_sched_pkg::*;
#(
  parameter int unsigned NUM_NONCES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [18:0][31:0] header,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [31:0]       result_nonce,
  output logic [31:0]       result_h0,
  output logic              sha_start,
  output logic [15:0][31:0] sha_w,
  output logic [7:0][31:0]  sha_hash_in,
  input  logic [7:0][31:0]  sha_hash_out,
  input  logic              sha_done
);

  state_t      state_q, state_d;
  logic [31:0] nonce_q, nonce_d;
  hash_t       midstate_q, midstate_d;
  hash_t       first_hash_q, first_hash_d;
  logic [31:0] result_h0_q, result_h0_d;
  block_t      sha_w_q, sha_w_d;
  hash_t       sha_hash_in_q, sha_hash_in_d;

  // The core inputs are loaded on the transition into each ISSUE state so
  // they are stable from the start pulse until the done pulse is consumed.
  always_comb begin
    state_d       = state_q;
    nonce_d       = nonce_q;
    midstate_d    = midstate_q;
    first_hash_d  = first_hash_q;
    result_h0_d   = result_h0_q;
    sha_w_d       = sha_w_q;
    sha_hash_in_d = sha_hash_in_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_P1_ISSUE;
          nonce_d       = '0;
          sha_w_d       = header[15:0];
          sha_hash_in_d = SHA256_IV;
        end
      end
      ST_P1_ISSUE: state_d = ST_P1_WAIT;
      ST_P1_WAIT: begin
        if (sha_done) begin
          state_d       = ST_P2_ISSUE;
          midstate_d    = sha_hash_out;
          sha_w_d       = p2_block(header[18:16], nonce_q);
          sha_hash_in_d = sha_hash_out;
        end
      end
      ST_P2_ISSUE: state_d = ST_P2_WAIT;
      ST_P2_WAIT: begin
        if (sha_done) begin
          state_d       = ST_P3_ISSUE;
          first_hash_d  = sha_hash_out;
          sha_w_d       = p3_block(sha_hash_out);
          sha_hash_in_d = SHA256_IV;
        end
      end
      ST_P3_ISSUE: state_d = ST_P3_WAIT;
      ST_P3_WAIT: begin
        if (sha_done) begin
          state_d     = ST_EMIT;
          result_h0_d = sha_hash_out[0];
        end
      end
      ST_EMIT: begin
        if (nonce_q == NUM_NONCES - 1) begin
          state_d = ST_DONE;
        end else begin
          // Midstate is reused, so the next nonce goes straight to pass 2.
          state_d       = ST_P2_ISSUE;
          nonce_d       = nonce_q + 32'd1;
          sha_w_d       = p2_block(header[18:16], nonce_q + 32'd1);
          sha_hash_in_d = midstate_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      nonce_q       <= '0;
      midstate_q    <= '0;
      first_hash_q  <= '0;
      result_h0_q   <= '0;
      sha_w_q       <= '0;
      sha_hash_in_q <= '0;
    end else begin
      state_q       <= state_d;
      nonce_q       <= nonce_d;
      midstate_q    <= midstate_d;
      first_hash_q  <= first_hash_d;
      result_h0_q   <= result_h0_d;
      sha_w_q       <= sha_w_d;
      sha_hash_in_q <= sha_hash_in_d;
    end
  end

  // Start is decoded from the ISSUE states only, so it can never linger into
  // a WAIT state or the cycle in which the core reports done.
  assign sha_start    = (state_q == ST_P1_ISSUE) || (state_q == ST_P2_ISSUE) ||
                        (state_q == ST_P3_ISSUE);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign result_valid = (state_q == ST_EMIT);
  assign result_nonce = nonce_q;
  assign result_h0    = result_h0_q;
  assign sha_w        = sha_w_q;
  assign sha_hash_in  = sha_hash_in_q;

endmodule
